// File: rtl/exe_ctrl.sv
// exe_ctrl: single-request execution controller.
// Accepts one operation at a time, steers it either to an external
// combinational ALU (ops 0-11, one-hot select) or to an external multi-cycle
// multiplier (op 12), guards the multiplier with a 6-bit watchdog, and holds
// the result until the consumer takes it. Ops 13-15 complete at once with
// out_err set.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake; in_op, in_src1, in_src2
//   alu_control              one-hot ALU select (bit 0 = ADD), ALU state only
//   alu_src1/2, alu_result   ALU operands and combinational result
//   mult_begin               level start/hold to multiplier, MUL state only
//   mult_op1/2, product      multiplier operands and 64-bit result
//   mult_end                 one-cycle multiplier done pulse
//   out_valid/out_ready      result handshake; out_lo, out_hi, out_err
//
// state | meaning
// IDLE  | waiting for a request (in_ready = 1)
// ALU   | single cycle driving alu_control, result captured at cycle end
// MUL   | mult_begin held high until mult_end or watchdog expiry
// DONE  | result held on outputs until out_ready
module exe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  output logic [11:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  input  logic [31:0] alu_result,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] product,
  input  logic        mult_end,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_lo,
  output logic [31:0] out_hi,
  output logic        out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ALU  = 2'd1,
    S_MUL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Watchdog expires on the 63rd MUL cycle: the count would reach 63 at the
  // end of it.
  localparam logic [5:0] WD_LAST = 6'd62;

  state_t      state, state_next;
  logic [3:0]  op_reg;
  logic [31:0] src1_reg, src2_reg;
  logic [5:0]  wd;
  logic        accept;

  assign accept   = in_valid && (state == S_IDLE);
  assign alu_src1 = src1_reg;
  assign alu_src2 = src2_reg;
  assign mult_op1 = src1_reg;
  assign mult_op2 = src2_reg;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    alu_control = 12'h000;
    mult_begin  = 1'b0;
    out_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_op <= 4'd11)      state_next = S_ALU;
          else if (in_op == 4'd12) state_next = S_MUL;
          else                     state_next = S_DONE;
        end
      end
      S_ALU: begin
        alu_control = 12'h001 << op_reg;
        state_next  = S_DONE;
      end
      S_MUL: begin
        mult_begin = 1'b1;
        // mult_end has priority over a simultaneous watchdog expiry
        if (mult_end || (wd == WD_LAST)) state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= 4'd0;
      src1_reg <= 32'd0;
      src2_reg <= 32'd0;
      wd       <= 6'd0;
      out_lo   <= 32'd0;
      out_hi   <= 32'd0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_reg   <= in_op;
            src1_reg <= in_src1;
            src2_reg <= in_src2;
            wd       <= 6'd0;
            if (in_op >= 4'd13) begin
              out_lo  <= 32'd0;
              out_hi  <= 32'd0;
              out_err <= 1'b1;
            end
          end
        end
        S_ALU: begin
          out_lo  <= alu_result;
          out_hi  <= 32'd0;
          out_err <= 1'b0;
        end
        S_MUL: begin
          wd <= wd + 6'd1;
          if (mult_end) begin
            out_hi  <= product[63:32];
            out_lo  <= product[31:0];
            out_err <= 1'b0;
          end else if (wd == WD_LAST) begin
            out_hi  <= 32'd0;
            out_lo  <= 32'd0;
            out_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_ctrl.sv
// tb_exe_ctrl: directed bench for exe_ctrl with a trivial ALU stand-in
// (ADD for bit 0, src1 XOR select otherwise) and a hand-driven multiplier.
module tb_exe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [11:0] alu_control;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_lo, out_hi;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_control == 12'h001) ? (alu_src1 + alu_src2)
                                               : (alu_src1 ^ {20'h0, alu_control});

  exe_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .product(product), .mult_end(mult_end),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lo(out_lo), .out_hi(out_hi), .out_err(out_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
    step();
    in_valid = 1'b0; in_op = 4'hF; in_src1 = 32'hDEAD_BEEF; in_src2 = 32'hBAD0_BAD0;
  endtask

  task automatic run_add_1111(input string tag);
    out_ready = 1'b1;
    issue(4'd0, 32'h0000_1111, 32'h0000_1111);
    chk({tag, "_alu_ctl"}, 64'(alu_control), 64'h001);
    chk({tag, "_alu_src1"}, 64'(alu_src1), 64'h1111);
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    chk({tag, "_no_valid_n1"}, 64'(out_valid), 64'd0);
    step();
    chk({tag, "_valid_n2"}, 64'(out_valid), 64'd1);
    chk({tag, "_lo"}, 64'(out_lo), 64'h2222);
    chk({tag, "_hi"}, 64'(out_hi), 64'd0);
    chk({tag, "_err"}, 64'(out_err), 64'd0);
    chk({tag, "_alu_ctl_off"}, 64'(alu_control), 64'h000);
    step();
    chk({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int hi_cnt;
    logic [11:0] exp_ctl;
    logic [31:0] a, exp_lo;

    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_src1 = 32'd0; in_src2 = 32'd0;
    product = 64'd0; mult_end = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_lo", 64'(out_lo), 64'd0);
    chk("rst_out_hi", 64'(out_hi), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_mult_begin", 64'(mult_begin), 64'd0);
    chk("rst_alu_ctl", 64'(alu_control), 64'd0);
    chk("rst_mult_op1", 64'(mult_op1), 64'd0);

    run_add_1111("add");

    // walk all ALU ops
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a = 32'h1000_0000 + 32'(i);
      exp_ctl = 12'h001 << i;
      exp_lo = (i == 0) ? (a + 32'd5) : (a ^ {20'h0, exp_ctl});
      issue(4'(i), a, 32'd5);
      chk($sformatf("walk%0d_ctl", i), 64'(alu_control), 64'(exp_ctl));
      step();
      chk($sformatf("walk%0d_ctl_off", i), 64'(alu_control), 64'h000);
      chk($sformatf("walk%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("walk%0d_lo", i), 64'(out_lo), 64'(exp_lo));
      step();
      chk($sformatf("walk%0d_idle_ctl", i), 64'(alu_control), 64'h000);
    end

    // multiply finishing on the 33rd MUL cycle
    issue(4'd12, 32'hFFFF_FFFF, 32'h0000_0002);
    chk("mul_op1", 64'(mult_op1), 64'hFFFF_FFFF);
    chk("mul_op2", 64'(mult_op2), 64'h2);
    hi_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mult_begin) hi_cnt++;
      if (c == 33) begin
        mult_end = 1'b1; product = 64'h0000_0001_FFFF_FFFE;
      end
      step();
      mult_end = 1'b0; product = 64'h5555_5555_5555_5555;
      if (c == 33) break;
    end
    chk("mul_begin_cycles", 64'(hi_cnt), 64'd33);
    chk("mul_begin_off", 64'(mult_begin), 64'd0);
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_hi", 64'(out_hi), 64'h1);
    chk("mul_lo", 64'(out_lo), 64'hFFFF_FFFE);
    chk("mul_err", 64'(out_err), 64'd0);
    step();

    // illegal op
    issue(4'd14, 32'h1234_5678, 32'h9ABC_DEF0);
    chk("ill_valid", 64'(out_valid), 64'd1);
    chk("ill_err", 64'(out_err), 64'd1);
    chk("ill_lo", 64'(out_lo), 64'd0);
    chk("ill_hi", 64'(out_hi), 64'd0);
    chk("ill_mult_begin", 64'(mult_begin), 64'd0);
    chk("ill_alu_ctl", 64'(alu_control), 64'd0);
    step();

    // watchdog timeout, then hold with out_ready low
    out_ready = 1'b0;
    issue(4'd12, 32'd3, 32'd4);
    hi_cnt = 0;
    for (int c = 1; c <= 63; c++) begin
      if (mult_begin) hi_cnt++;
      if (out_valid) hi_cnt = hi_cnt + 100;
      step();
    end
    chk("wd_begin_cycles", 64'(hi_cnt), 64'd63);
    chk("wd_valid", 64'(out_valid), 64'd1);
    chk("wd_err", 64'(out_err), 64'd1);
    chk("wd_lo", 64'(out_lo), 64'd0);
    chk("wd_hi", 64'(out_hi), 64'd0);
    chk("wd_begin_off", 64'(mult_begin), 64'd0);
    for (int c = 0; c < 10; c++) begin
      mult_end = (c == 4); product = 64'hFFFF_FFFF_FFFF_FFFF;
      step();
      chk($sformatf("hold%0d", c), {29'd0, out_valid, out_err, in_ready, out_lo}, 64'h0000_0006_0000_0000);
    end
    mult_end = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release", 64'(in_ready), 64'd1);

    // mult_end on the watchdog's last cycle wins
    issue(4'd12, 32'd7, 32'd9);
    for (int c = 1; c <= 63; c++) begin
      if (c == 63) begin
        mult_end = 1'b1; product = 64'h0000_0000_0000_003F;
      end
      step();
      mult_end = 1'b0;
    end
    chk("tie_valid", 64'(out_valid), 64'd1);
    chk("tie_err", 64'(out_err), 64'd0);
    chk("tie_lo", 64'(out_lo), 64'h3F);
    step();

    // reset abort mid-MUL
    out_ready = 1'b1;
    issue(4'd12, 32'hAAAA_AAAA, 32'h5555_5555);
    for (int c = 0; c < 10; c++) step();
    chk("abort_pre_begin", 64'(mult_begin), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_idle", 64'(in_ready), 64'd1);
    chk("abort_begin", 64'(mult_begin), 64'd0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_lo", 64'(out_lo), 64'd0);
    chk("abort_op1", 64'(mult_op1), 64'd0);
    for (int c = 0; c < 4; c++) step();
    mult_end = 1'b1; product = 64'h1111_2222_3333_4444;
    step();
    mult_end = 1'b0;
    chk("stray_valid", 64'(out_valid), 64'd0);
    chk("stray_idle", 64'(in_ready), 64'd1);
    chk("stray_lo", 64'(out_lo), 64'd0);
    run_add_1111("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
